// File: rtl/sar_decision_ctrl.sv
// SAR decision controller for a dynamic-comparator front-end.
// Sequences sample, precharge and evaluate phases and assembles the result word.
module sar_decision_ctrl #(
    parameter int NBIT       = 8,
    parameter int SAMPLE_CYC = 2
) (
    input  logic            CK,
    input  logic            RN,
    input  logic            START,
    input  logic            CMP_OUT,
    output logic            CMP_CK,
    output logic            SAMPLE,
    output logic [NBIT-1:0] DAC,
    output logic [NBIT-1:0] DOUT,
    output logic            BUSY,
    output logic            DONE
);

    localparam int IW = (NBIT > 1) ? $clog2(NBIT) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NBIT - 1);
    localparam logic [3:0] CNT_LAST = 4'(SAMPLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SMPL,
        PRE,
        EVAL,
        FIN
    } state_t;

    state_t          state;
    logic [NBIT-1:0] result;
    logic [IW-1:0]   idx;
    logic [3:0]      cnt;
    logic [NBIT-1:0] decided;

    function automatic logic [NBIT-1:0] bit_at(input logic [IW-1:0] i);
        logic [NBIT-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Result with the bit under test resolved by the latched comparator decision
    always_comb begin
        decided = result;
        if (CMP_OUT) decided = result | bit_at(idx);
    end

    // Conversion sequencer; every output is a register updated here
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state  <= IDLE;
            CMP_CK <= 1'b0;
            SAMPLE <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            DAC    <= '0;
            DOUT   <= '0;
            result <= '0;
            idx    <= IDX_TOP;
            cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    CMP_CK <= 1'b0;
                    DONE   <= 1'b0;
                    BUSY   <= 1'b0;
                    if (START) begin
                        state  <= SMPL;
                        SAMPLE <= 1'b1;
                        BUSY   <= 1'b1;
                        result <= '0;
                        idx    <= IDX_TOP;
                        cnt    <= '0;
                    end
                end
                SMPL: begin
                    if (cnt == CNT_LAST) begin
                        state  <= PRE;
                        SAMPLE <= 1'b0;
                        DAC    <= result | bit_at(idx);
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                PRE: begin
                    state  <= EVAL;
                    CMP_CK <= 1'b1;
                end
                EVAL: begin
                    CMP_CK <= 1'b0;
                    result <= decided;
                    if (idx != '0) begin
                        idx   <= idx - 1'b1;
                        DAC   <= decided | bit_at(idx - 1'b1);
                        state <= PRE;
                    end else begin
                        DOUT  <= decided;
                        DAC   <= decided;
                        DONE  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_decision_ctrl.sv
// Directed bench for sar_decision_ctrl with a behavioural comparator
// and a scoreboard of expected results and DONE cycles.
module tb_sar_decision_ctrl;

    localparam int NBIT = 8;
    localparam int SC   = 2;
    localparam int LAT  = SC + 2 * NBIT;

    logic            CK    = 1'b0;
    logic            RN    = 1'b1;
    logic            START = 1'b0;
    logic            CMP_OUT;
    logic            CMP_CK;
    logic            SAMPLE;
    logic [NBIT-1:0] DAC;
    logic [NBIT-1:0] DOUT;
    logic            BUSY;
    logic            DONE;
    logic [NBIT-1:0] code = '0;

    typedef struct {
        logic [NBIT-1:0] val;
        int              at;
    } exp_t;

    exp_t            sb[$];
    logic [NBIT-1:0] trials[$];
    int              done_at[$];
    int              checks    = 0;
    int              failures  = 0;
    int              cyc       = 0;
    int              done_seen = 0;
    int              cmp_hi    = 0;

    sar_decision_ctrl #(.NBIT(NBIT), .SAMPLE_CYC(SC)) dut (
        .CK     (CK),
        .RN     (RN),
        .START  (START),
        .CMP_OUT(CMP_OUT),
        .CMP_CK (CMP_CK),
        .SAMPLE (SAMPLE),
        .DAC    (DAC),
        .DOUT   (DOUT),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    // Comparator is only meaningful while evaluating; X otherwise
    assign CMP_OUT = CMP_CK ? (code >= DAC) : 1'bx;

    always #5 CK = ~CK;

    always @(posedge CK) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {12'b0, CMP_CK, SAMPLE, BUSY, DONE, DAC, DOUT}, 32'h0);
    endtask

    task automatic start_conv(input logic [NBIT-1:0] c);
        @(negedge CK);
        code  = c;
        START = 1'b1;
        sb.push_back('{c, cyc + 1 + LAT});
        @(negedge CK);
        START = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        bit got;
        d0  = done_seen;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CK);
            #1;
            if (done_seen != d0) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_timeout", 32'(got), 32'h1);
    endtask

    // Protocol monitor and scoreboard consumer
    always @(negedge CK) begin
        if (!RN) begin
            cmp_hi = 0;
        end else begin
            chk("sample_cmpck_excl", 32'(SAMPLE & CMP_CK), 32'h0);
            if (CMP_CK) begin
                cmp_hi++;
                trials.push_back(DAC);
            end
            if (DONE) begin
                exp_t e;
                done_seen++;
                done_at.push_back(cyc);
                chk("done_busy", 32'(BUSY), 32'h1);
                chk("cmp_ck_cycles", cmp_hi, NBIT);
                cmp_hi = 0;
                chk("sb_nonempty", 32'(sb.size() > 0), 32'h1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("dout", 32'(DOUT), 32'(e.val));
                    chk("latency", cyc, e.at);
                end
            end
        end
    end

    initial begin
        logic [NBIT-1:0] tr_exp[8];
        int d0;
        int n;
        tr_exp = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

        #2 RN = 1'b0;
        repeat (3) begin
            @(negedge CK);
            chk_zero("reset_state");
        end
        RN = 1'b1;
        repeat (10) begin
            @(negedge CK);
            chk_zero("idle_state");
        end

        trials.delete();
        start_conv(8'hA5);
        wait_done(40);
        chk("trial_count", trials.size(), 8);
        for (int i = 0; i < 8 && i < trials.size(); i++)
            chk($sformatf("trial%0d", i), 32'(trials[i]), 32'(tr_exp[i]));
        @(negedge CK);
        chk("busy_after_fin", 32'(BUSY), 32'h0);
        chk("dac_hold", 32'(DAC), 32'hA5);
        chk("dout_hold", 32'(DOUT), 32'hA5);

        start_conv(8'h00);
        wait_done(40);
        start_conv(8'hFF);
        wait_done(40);
        chk("dout_ff", 32'(DOUT), 32'hFF);

        d0 = done_seen;
        start_conv(8'h5A);
        repeat (5) @(negedge CK);
        START = 1'b1;
        @(negedge CK);
        START = 1'b0;
        wait_done(40);
        repeat (25) @(negedge CK);
        chk("start_ignored", done_seen - d0, 1);
        chk("idle_after_ignore", 32'(BUSY), 32'h0);

        @(negedge CK);
        code  = 8'h3C;
        START = 1'b1;
        sb.push_back('{8'h3C, cyc + 1 + LAT});
        sb.push_back('{8'hC3, cyc + 1 + LAT + LAT + 2});
        wait_done(40);
        code = 8'hC3;
        wait_done(40);
        START = 1'b0;
        chk("b2b_period", done_at[done_at.size()-1] - done_at[done_at.size()-2],
            LAT + 2);
        chk("b2b_dout", 32'(DOUT), 32'hC3);

        repeat (3) @(negedge CK);
        start_conv(8'h77);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CK);
            if (CMP_CK) n++;
            if (n == 4) break;
        end
        chk("eval4_reached", n, 4);
        #1 RN = 1'b0;
        #1 chk_zero("async_reset");
        sb.delete();
        repeat (2) @(negedge CK);
        chk_zero("reset_hold");
        RN = 1'b1;
        start_conv(8'h5C);
        wait_done(40);
        chk("post_reset_dout", 32'(DOUT), 32'h5C);

        repeat (3) @(negedge CK);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
